// File: rtl/genius_pkg.sv
// Shared state encodings, symbol codes and default timing for the Genius round sequencer.
package genius_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SHOW_ON    = 3'd1,
        ST_SHOW_GAP   = 3'd2,
        ST_WAIT_INPUT = 3'd3,
        ST_LEVEL_UP   = 3'd4,
        ST_LOSE       = 3'd5,
        ST_WIN        = 3'd6
    } state_e;

    localparam logic [1:0] SYM_0    = 2'd0;
    localparam logic [1:0] SYM_1    = 2'd1;
    localparam logic [1:0] SYM_2    = 2'd2;
    localparam logic [1:0] SYM_NONE = 2'd3;

    localparam int unsigned DEF_SHOW_ON_TICKS       = 25000000;
    localparam int unsigned DEF_SHOW_GAP_TICKS      = 12500000;
    localparam int unsigned DEF_INPUT_TIMEOUT_TICKS = 250000000;
    localparam int unsigned DEF_MAX_LEVEL           = 15;
    localparam int unsigned DEF_TIMER_W             = 28;

endpackage

// File: rtl/genius_press_detect.sv
// Button rising-edge detection and classification of a press against the expected symbol.
module genius_press_detect
    import genius_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] btn_i,
    input  logic [1:0] seq_symbol_i,
    output logic       press_any_o,
    output logic       press_hit_o
);

    logic [2:0] btn_q;
    logic [2:0] press;
    logic [2:0] exp_vec;
    logic       one_hot;

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_q <= 3'b000;
        end else begin
            btn_q <= btn_i;
        end
    end

    // An invalid stored symbol maps to an empty mask so no press can ever match it.
    always_comb begin
        exp_vec = 3'b000;
        if (seq_symbol_i != SYM_NONE) begin
            exp_vec = 3'b001 << seq_symbol_i;
        end
    end

    assign press       = btn_i & ~btn_q;
    assign one_hot     = (press != 3'b000) && ((press & (press - 3'd1)) == 3'b000);
    assign press_any_o = (press != 3'b000);
    assign press_hit_o = one_hot && (press == exp_vec);

endmodule

// File: rtl/genius_round_ctrl.sv
// Genius round sequencer: plays back the sequence for the current level, then checks player presses.
//   state       | meaning
//   IDLE        | waiting for first start
//   SHOW_ON     | symbol at seq_idx displayed
//   SHOW_GAP    | blank after a displayed symbol
//   WAIT_INPUT  | waiting for the press matching seq_idx
//   LEVEL_UP    | level complete, advance or win
//   LOSE / WIN  | game ended, outputs held until start
module genius_round_ctrl
    import genius_pkg::*;
#(
    parameter int unsigned SHOW_ON_TICKS       = DEF_SHOW_ON_TICKS,
    parameter int unsigned SHOW_GAP_TICKS      = DEF_SHOW_GAP_TICKS,
    parameter int unsigned INPUT_TIMEOUT_TICKS = DEF_INPUT_TIMEOUT_TICKS,
    parameter int unsigned MAX_LEVEL           = DEF_MAX_LEVEL,
    parameter int unsigned TIMER_W             = DEF_TIMER_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] btn,
    input  logic [1:0] seq_symbol,
    output logic [3:0] seq_idx,
    output logic       show_active,
    output logic [1:0] show_symbol,
    output logic       input_active,
    output logic [3:0] level,
    output logic       hit_pulse,
    output logic       game_over,
    output logic       game_won,
    output logic [2:0] state_dbg
);

    state_e               state_q, state_d;
    logic [3:0]           seq_idx_q, seq_idx_d;
    logic [3:0]           level_q, level_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 start_q;
    logic                 hit_q, hit_d;
    logic                 show_active_q, input_active_q, game_over_q, game_won_q;
    logic                 start_rise;
    logic                 press_any, press_hit;

    genius_press_detect u_press (
        .clock        (clock),
        .reset        (reset),
        .btn_i        (btn),
        .seq_symbol_i (seq_symbol),
        .press_any_o  (press_any),
        .press_hit_o  (press_hit)
    );

    assign start_rise = start & ~start_q;

    always_comb begin
        state_d   = state_q;
        seq_idx_d = seq_idx_q;
        level_d   = level_q;
        timer_d   = timer_q;
        hit_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOSE, ST_WIN: begin
                if (start_rise) begin
                    level_d   = 4'd0;
                    seq_idx_d = 4'd0;
                    timer_d   = '0;
                    state_d   = ST_SHOW_ON;
                end
            end
            ST_SHOW_ON: begin
                if (timer_q == TIMER_W'(SHOW_ON_TICKS - 1)) begin
                    timer_d = '0;
                    state_d = ST_SHOW_GAP;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_SHOW_GAP: begin
                if (timer_q == TIMER_W'(SHOW_GAP_TICKS - 1)) begin
                    timer_d = '0;
                    if (seq_idx_q == level_q) begin
                        seq_idx_d = 4'd0;
                        state_d   = ST_WAIT_INPUT;
                    end else begin
                        seq_idx_d = seq_idx_q + 4'd1;
                        state_d   = ST_SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_WAIT_INPUT: begin
                // A press on the timeout cycle is evaluated ahead of the timeout.
                if (press_hit) begin
                    hit_d   = 1'b1;
                    timer_d = '0;
                    if (seq_idx_q == level_q) begin
                        state_d = ST_LEVEL_UP;
                    end else begin
                        seq_idx_d = seq_idx_q + 4'd1;
                    end
                end else if (press_any) begin
                    state_d = ST_LOSE;
                end else if (timer_q == TIMER_W'(INPUT_TIMEOUT_TICKS - 1)) begin
                    state_d = ST_LOSE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_LEVEL_UP: begin
                if (level_q == 4'(MAX_LEVEL)) begin
                    state_d = ST_WIN;
                end else begin
                    level_d   = level_q + 4'd1;
                    seq_idx_d = 4'd0;
                    timer_d   = '0;
                    state_d   = ST_SHOW_ON;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            seq_idx_q      <= 4'd0;
            level_q        <= 4'd0;
            timer_q        <= '0;
            start_q        <= 1'b0;
            hit_q          <= 1'b0;
            show_active_q  <= 1'b0;
            input_active_q <= 1'b0;
            game_over_q    <= 1'b0;
            game_won_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_idx_q      <= seq_idx_d;
            level_q        <= level_d;
            timer_q        <= timer_d;
            start_q        <= start;
            hit_q          <= hit_d;
            show_active_q  <= (state_d == ST_SHOW_ON);
            input_active_q <= (state_d == ST_WAIT_INPUT);
            game_over_q    <= (state_d == ST_LOSE);
            game_won_q     <= (state_d == ST_WIN);
        end
    end

    assign seq_idx      = seq_idx_q;
    assign level        = level_q;
    assign hit_pulse    = hit_q;
    assign show_active  = show_active_q;
    assign input_active = input_active_q;
    assign game_over    = game_over_q;
    assign game_won     = game_won_q;
    assign state_dbg    = state_q;
    assign show_symbol  = show_active_q ? seq_symbol : 2'd0;

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Scoreboard bench: a game-level model predicts displayed symbols, prompts, hits and endings with cycle stamps.
module tb_genius_round_ctrl;

    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int TO   = 20;
    localparam int MAXL = 2;

    localparam int EV_SHOW  = 1;
    localparam int EV_INPUT = 2;
    localparam int EV_HIT   = 3;
    localparam int EV_LOSE  = 4;
    localparam int EV_WIN   = 5;

    localparam int M_OK      = 0;
    localparam int M_WRONG   = 1;
    localparam int M_MULTI   = 2;
    localparam int M_TIMEOUT = 3;
    localparam int M_LATE    = 4;
    localparam int M_HELD    = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] btn;
    logic [1:0] seq_symbol;
    logic [3:0] seq_idx;
    logic       show_active;
    logic [1:0] show_symbol;
    logic       input_active;
    logic [3:0] level;
    logic       hit_pulse;
    logic       game_over;
    logic       game_won;
    logic [2:0] state_dbg;

    typedef struct {
        int kind;
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  mon_en   = 1'b0;

    genius_round_ctrl #(
        .SHOW_ON_TICKS       (ON),
        .SHOW_GAP_TICKS      (GAP),
        .INPUT_TIMEOUT_TICKS (TO),
        .MAX_LEVEL           (MAXL),
        .TIMER_W             (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .btn          (btn),
        .seq_symbol   (seq_symbol),
        .seq_idx      (seq_idx),
        .show_active  (show_active),
        .show_symbol  (show_symbol),
        .input_active (input_active),
        .level        (level),
        .hit_pulse    (hit_pulse),
        .game_over    (game_over),
        .game_won     (game_won),
        .state_dbg    (state_dbg)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Sequence memory contents 2,1,0,1; anything beyond is an invalid symbol.
    function automatic int sym(input int i);
        case (i)
            0: return 2;
            1: return 1;
            2: return 0;
            3: return 1;
            default: return 3;
        endcase
    endfunction

    assign seq_symbol = 2'(sym(int'(seq_idx)));

    function automatic bit ref_correct(input logic [2:0] v, input int s);
        return ($countones(v) == 1) && (s < 3) && v[s];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int k, input int c, input int a, input int b);
        exp_q.push_back('{k, c, a, b});
    endtask

    task automatic pop_ev(input int k, input int c, input int a, input int b);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event kind=%0d cycle=%0d a=%0d b=%0d, expected none", k, c, a, b);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", c, e.cyc);
            check("event_a", a, e.a);
            check("event_b", b, e.b);
        end
    endtask

    // Monitor: turns DUT output transitions into events and retires them against the scoreboard.
    initial begin
        bit prev_show, prev_inp, prev_over, prev_won, sym_bad;
        int show_start, show_len, show_sym;
        prev_show = 0; prev_inp = 0; prev_over = 0; prev_won = 0; sym_bad = 0;
        show_start = 0; show_len = 0; show_sym = 0;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (prev_show && !show_active)
                    pop_ev(EV_SHOW, show_start, sym_bad ? 7 : show_sym, show_len);
                if (show_active && !prev_show) begin
                    show_start = cyc;
                    show_len   = 1;
                    show_sym   = int'(show_symbol);
                    sym_bad    = 0;
                end else if (show_active) begin
                    show_len++;
                    if (int'(show_symbol) != show_sym) sym_bad = 1;
                end
                if (!show_active) check("show_symbol_gated", show_symbol, 0);
                if (input_active && !prev_inp) pop_ev(EV_INPUT, cyc, int'(level), int'(seq_idx));
                if (hit_pulse) pop_ev(EV_HIT, cyc, int'(level), int'(seq_idx));
                if (game_over && !prev_over) begin
                    pop_ev(EV_LOSE, cyc, int'(level), int'(seq_idx));
                    check("lose_input_inactive", input_active, 0);
                end
                if (game_won && !prev_won) pop_ev(EV_WIN, cyc, int'(level), int'(seq_idx));
                prev_show = show_active;
                prev_inp  = input_active;
                prev_over = game_over;
                prev_won  = game_won;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic start_game(output int base);
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        base = cyc;
    endtask

    // A level plays every symbol 0..L for ON cycles with GAP blank cycles each, then prompts.
    task automatic push_level(input int L, input int base, output int inp);
        for (int i = 0; i <= L; i++) push(EV_SHOW, base + i * (ON + GAP), sym(i), ON);
        inp = base + (L + 1) * (ON + GAP);
        push(EV_INPUT, inp, L, 0);
    endtask

    task automatic wait_input(output bit ok);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (input_active) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_input_timeout at cycle %0d: input_active never rose, expected 1", cyc);
        end
    endtask

    task automatic play_game(input bit rnd, input int fmode, input int flvl, input bit glitch,
                             output int res, output int out_l, output int out_i);
        int base, inp, t_ref, edge_c, n, hold, m, s, r;
        logic [2:0] v;
        bit ok, good;
        logic [2:0] multi_tab [4];
        multi_tab[0] = 3'b011; multi_tab[1] = 3'b101; multi_tab[2] = 3'b110; multi_tab[3] = 3'b111;
        res = 0; out_l = 0; out_i = 0;
        start_game(base);
        for (int L = 0; L <= MAXL; L++) begin
            push_level(L, base, inp);
            if (glitch && L == 0) begin
                tick(2);
                start = 1'b1;
                tick(1);
                start = 1'b0;
            end
            if (fmode == M_HELD && flvl == L) begin
                for (int k = 0; k < 200 && cyc < inp - 2; k++) @(negedge clock);
                btn = 3'b001 << sym(0);
            end
            wait_input(ok);
            if (!ok) begin
                out_l = L;
                return;
            end
            t_ref = cyc;
            for (int i = 0; i <= L; i++) begin
                m = (flvl == L && i == 0) ? fmode : M_OK;
                if (rnd && m == M_OK) begin
                    r = $urandom_range(0, 99);
                    m = (r < 80) ? M_OK : (r < 88) ? M_WRONG : (r < 95) ? M_MULTI : M_TIMEOUT;
                end
                if (m == M_HELD) begin
                    tick(3);
                    check("held_btn_no_hit", hit_pulse, 0);
                    check("held_btn_still_waiting", input_active, 1);
                    btn = 3'b000;
                    m = M_OK;
                end
                s = sym(i);
                case (m)
                    M_WRONG: v = 3'b001 << ((s + (rnd ? $urandom_range(1, 2) : 2)) % 3);
                    M_MULTI: v = rnd ? multi_tab[$urandom_range(0, 3)] : 3'b101;
                    M_TIMEOUT: v = 3'b000;
                    default: v = 3'b001 << s;
                endcase
                if (m == M_TIMEOUT) begin
                    push(EV_LOSE, t_ref + TO, L, i);
                    while (cyc < t_ref + TO + 1) tick(1);
                    out_l = L;
                    out_i = i;
                    return;
                end
                n = (m == M_LATE) ? (t_ref + TO - 1 - cyc) : $urandom_range(1, 6);
                tick(n);
                btn = v;
                edge_c = cyc + 1;
                good = ref_correct(v, s);
                if (good) begin
                    push(EV_HIT, edge_c, L, (i == L) ? L : i + 1);
                    if (i == L && L == MAXL) push(EV_WIN, edge_c + 1, MAXL, MAXL);
                end else begin
                    push(EV_LOSE, edge_c, L, i);
                end
                hold = $urandom_range(1, 3);
                tick(hold);
                btn = 3'b000;
                if (!good) begin
                    tick(1);
                    out_l = L;
                    out_i = i;
                    return;
                end
                t_ref = edge_c;
                if (i == L) base = edge_c + 1;
            end
        end
        res = 1;
        out_l = MAXL;
        out_i = MAXL;
    endtask

    task automatic check_end(input int res, input int l, input int i);
        tick($urandom_range(2, 6));
        check("end_game_won", game_won, res);
        check("end_game_over", game_over, 1 - res);
        check("end_level_frozen", level, l);
        check("end_seq_idx_frozen", seq_idx, i);
        check("end_input_inactive", input_active, 0);
        check("end_show_inactive", show_active, 0);
        check("end_state", state_dbg, res ? 6 : 5);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_show_active"}, show_active, 0);
        check({tag, "_input_active"}, input_active, 0);
        check({tag, "_hit_pulse"}, hit_pulse, 0);
        check({tag, "_game_over"}, game_over, 0);
        check({tag, "_game_won"}, game_won, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_seq_idx"}, seq_idx, 0);
        check({tag, "_state"}, state_dbg, 0);
        check({tag, "_show_symbol"}, show_symbol, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected test end", cyc);
        $fatal(1);
    end

    initial begin
        int res, l, i, base, inp;
        bit ok;
        reset = 1'b1;
        start = 1'b0;
        btn   = 3'b000;
        tick(3);
        check_idle("reset");
        reset = 1'b0;
        mon_en = 1'b1;

        play_game(0, M_OK, 0, 0, res, l, i);
        check_end(res, l, i);
        play_game(0, M_WRONG, 1, 0, res, l, i);
        check_end(res, l, i);
        play_game(0, M_MULTI, 0, 0, res, l, i);
        check_end(res, l, i);
        play_game(0, M_TIMEOUT, 0, 0, res, l, i);
        check_end(res, l, i);
        play_game(0, M_LATE, 0, 0, res, l, i);
        check_end(res, l, i);
        play_game(0, M_HELD, 1, 1, res, l, i);
        check_end(res, l, i);

        start_game(base);
        push_level(0, base, inp);
        wait_input(ok);
        tick(2);
        reset = 1'b1;
        tick(1);
        check_idle("mid_reset");
        reset = 1'b0;
        tick(1);

        for (int g = 0; g < 8; g++) begin
            play_game(1, M_OK, 0, 0, res, l, i);
            check_end(res, l, i);
        end

        tick(10);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
